// File: rtl/psum_collector_pkg.sv
// ============================================================================
//  psum_pkg
//  Shared constants and helpers for the partial-sum collector.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package psum_pkg;

    localparam int PSUM_BW_DEFAULT = 16;
    localparam int DEPTH_DEFAULT   = 16;

    // Occupancy needs one bit more than the pointer so "full" is representable.
    function automatic int occ_width(input int fifo_depth);
        return $clog2(fifo_depth) + 1;
    endfunction

    function automatic int lane_lsb(input int lane, input int lane_bw);
        return lane * lane_bw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/psum_col_fifo.sv
// ============================================================================
//  psum_col_fifo
//  Single-lane FIFO with wrap-bit pointers and a combinational head read.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module psum_col_fifo
    import psum_pkg::*;
#(
    parameter int width = PSUM_BW_DEFAULT,
    parameter int depth = DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [width-1:0]             din,
    output logic [width-1:0]             dout,
    output logic                         empty,
    output logic                         full,
    output logic [occ_width(depth)-1:0]  occupancy
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0] c_PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointer MSB is the wrap bit.
    logic [AW:0]       wr_q, wr_d;
    logic [AW:0]       rd_q, rd_d;
    logic [width-1:0]  mem_q [depth];

    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign occupancy = wr_q - rd_q;
    assign dout      = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = push ? (wr_q + c_PTR_ONE) : wr_q;
        rd_d = pop  ? (rd_q + c_PTR_ONE) : rd_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (push) begin
                mem_q[wr_q[AW-1:0]] <= din;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/psum_collector.sv
// ============================================================================
//  psum_collector
//  Realigns skewed south-edge partial sums into rows with ready/valid output.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module psum_collector
    import psum_pkg::*;
#(
    parameter int col     = 8,
    parameter int psum_bw = PSUM_BW_DEFAULT,
    parameter int depth   = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [col*psum_bw-1:0]   in_psum,
    input  logic [col-1:0]           in_valid,
    input  logic                     relu_en,
    output logic [col*psum_bw-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [15:0]              row_count
);

    localparam int OCC_W  = occ_width(depth);
    localparam int AF_INT = (depth > col) ? (depth - col) : 0;
    localparam logic [OCC_W-1:0] c_AF_LEVEL = OCC_W'(AF_INT);

    logic [col-1:0] w_empty;
    logic [col-1:0] w_full;
    logic [col-1:0] w_push;
    logic [col-1:0] w_drop;
    logic [col-1:0] w_near;
    logic           w_pop;

    logic        almost_full_q, almost_full_d;
    logic        overflow_q,    overflow_d;
    logic [15:0] row_count_q,   row_count_d;

    assign out_valid = ~|w_empty;
    assign w_pop     = out_valid & out_ready;

    for (genvar j = 0; j < col; j++) begin : g_lane
        logic [psum_bw-1:0] w_head;
        logic [OCC_W-1:0]   w_occ;

        // A full lane that pops this cycle frees its head slot for the push.
        assign w_push[j] = in_valid[j] & (~w_full[j] | w_pop);
        assign w_drop[j] = in_valid[j] &  w_full[j] & ~w_pop;
        assign w_near[j] = (w_occ >= c_AF_LEVEL);

        psum_col_fifo #(
            .width (psum_bw),
            .depth (depth)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (w_push[j]),
            .pop       (w_pop),
            .din       (in_psum[lane_lsb(j, psum_bw) +: psum_bw]),
            .dout      (w_head),
            .empty     (w_empty[j]),
            .full      (w_full[j]),
            .occupancy (w_occ)
        );

        assign out_data[lane_lsb(j, psum_bw) +: psum_bw] =
            (relu_en && w_head[psum_bw-1]) ? '0 : w_head;
    end

    always_comb begin
        almost_full_d = |w_near;
        overflow_d    = overflow_q | (|w_drop);
        row_count_d   = w_pop ? (row_count_q + 16'd1) : row_count_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            row_count_q   <= '0;
        end else begin
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            row_count_q   <= row_count_d;
        end
    end

    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;
    assign row_count   = row_count_q;

endmodule

`default_nettype wire

// File: doc/psum_collector.md
# psum_collector

Output-side collector for the systolic MAC array. Captures the partial sums leaving the south edge of the bottom tile row, one lane per column, each qualified by that tile's `valid`. Column outputs arrive skewed by column index; per-column FIFOs realign them. Complete rows go downstream over a ready/valid handshake, with optional ReLU, and the block raises backpressure toward the array controller before any column can overflow.

## Interface
Parameters:
- `col`, 8: number of array columns / lanes.
- `psum_bw`, 16: partial-sum width, two's complement.
- `depth`, 16: entries per column FIFO; must be a power of two and at least 4.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low; asserting it clears all state immediately.
- `in_psum`  in  col*psum_bw: bottom-row `out_s` values; lane j occupies bits [(j+1)*psum_bw-1 : j*psum_bw].
- `in_valid`  in  col: per-lane capture strobe, driven from each bottom tile's `valid`.
- `relu_en`  in  1: when 1, negative output lanes are replaced by 0.
- `out_data`  out  col*psum_bw: realigned row, with the same lane packing as `in_psum`.
- `out_valid`  out  1: a complete row is available on `out_data`.
- `out_ready`  in  1: the downstream consumer accepts the row.
- `almost_full`  out  1: backpressure to the array controller.
- `overflow`  out  1: sticky error flag.
- `row_count`  out  16: number of rows popped since reset; wraps modulo 2^16.

## Operation
- Each lane has its own FIFO with write pointer, read pointer, and one wrap bit per pointer.
  - Full: pointers equal, wrap bits differ.
  - Empty: pointers and wrap bits both equal.
- Push, lane j: happens when `in_valid[j]` is 1 and the lane is not full. A lane that is full but popping in the same cycle counts as not full, so push and pop both proceed.
- Dropped push: if `in_valid[j]` is 1, the lane is full and no pop occurs, the data is discarded and `overflow` is set. `overflow` stays set until reset.
- `out_valid` = 1 exactly when every lane is non-empty.
- Pop = `out_valid` AND `out_ready`. It advances all read pointers together and increments `row_count`.
- Holding: while `out_valid` is 1 and `out_ready` is 0, `out_data` stays stable. `out_valid` never drops without a pop, except on reset.
- `out_data` is taken combinationally from each lane's head entry.
- ReLU: when `relu_en` is 1, each lane with sign bit 1 outputs 0, and all other lanes pass through unchanged. `relu_en` is sampled combinationally and is expected to be static during a run.
- `almost_full` = 1 when any lane's occupancy is at least `depth` − `col`. This leaves room for the skewed tail of one row already in flight.
- Lanes with no `in_valid` in a given cycle are untouched. Partial rows remain buffered indefinitely.

## Timing
- Reset values:
  - `out_valid` = 0
  - `almost_full` = 0
  - `overflow` = 0
  - `row_count` = 0
  - all pointers = 0
  - `out_data` = 0, because memory contents are don't-care but are reset to 0.
- Write latency: data pushed at edge N on the last lane needed to complete a row appears with `out_valid` = 1 in cycle N+1.
- Pop: accepted at the edge where `out_valid` and `out_ready` are both 1. If all lanes still hold data, the next row is presented in the following cycle with no bubble, giving throughput of 1 row per cycle.
- Skew: lane j typically receives row r j cycles after lane 0. The FIFOs absorb any skew smaller than `depth` rows.
- `almost_full` and `overflow` are registered and update one cycle after the occupancy change or dropped push that causes them.
- Reset asserted mid-stream: everything is discarded, and in-flight rows are lost without setting `overflow`.

## Structure
- Shared package `psum_pkg`:
  - `psum_bw` default
  - the lane-slice helper function
  - the occupancy width constant, $clog2(`depth`)+1
- Sub-module `psum_col_fifo`, one instance per lane via generate. Ports: push, pop, din, dout, empty, full, occupancy.
- The top level contains:
  - `out_valid`/pop logic
  - ReLU muxing
  - `almost_full` and `overflow` registers
  - `row_count`

## Test plan
- Unskewed rows: `col`=8, `depth`=16. Set all 8 `in_valid` in one cycle with lane j = j+1, and hold `out_ready`=1. Required: `out_valid` next cycle, `out_data` lanes = 1..8, `row_count`=1.
- Skewed arrival: lane j is valid in cycle j, for 4 rows, with lane value 100*r+j. Required: 4 rows come out in order, and `out_valid` first rises the cycle after lane 7's first write.
- Backpressure: `out_ready`=0 while 9 rows stream in. Required:
  - `almost_full` rises at occupancy 8
  - `out_data` holds row 0
  - no overflow
  - draining afterwards returns rows 0..8 in order.
- Overflow: push 17 entries into lane 3 with `out_ready`=0. Required: the 17th is dropped and `overflow`=1 sticky. Other lanes are unaffected.
- ReLU: lanes = −5, 7, −32768, 0, with `relu_en`=1. Required: output lanes = 0, 7, 0, 0. With `relu_en`=0 the values are unchanged.
- Reset mid-operation: assert `reset` low with 3 rows buffered. Required: `out_valid`, `row_count` and `overflow` go to 0 immediately. After release, a new row pops correctly.
